muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO register pair.
- Sits beside the execute stage and is started by DIV/DIVU/MULT/MULTU.
- Serves MFHI/MFLO reads and drives a pipeline stall while a result is pending.
- Uses an iterative shift-add/shift-subtract datapath so the single-cycle ALU stays short.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- STEPS_PER_CYCLE, 1: iteration bits retired per clock; legal values are 1, 2 and 4, and the value must divide WIDTH.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request a new operation; sampled on the rising edge.
- op, input, 2: 00 DIV, 01 DIVU, 10 MULT, 11 MULTU.
- opa, input, WIDTH: rs operand (dividend or multiplicand).
- opb, input, WIDTH: rt operand (divisor or multiplier).
- rd_req, input, 1: MFHI/MFLO read request.
- rd_sel, input, 1: 0 reads LO, 1 reads HI.
- rd_data, output, WIDTH: selected HI/LO value; combinational from the registers.
- busy, output, 1: an operation is in flight.
- stall, output, 1: the pipeline must hold its current instruction.
- done, output, 1: one-cycle pulse when HI/LO are updated.
- div_zero, output, 1: sticky flag; the last divide had opb == 0.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - HI = 0, LO = 0.
  - busy = 0, stall = 0, done = 0, div_zero = 0.
  - Iteration counter and working registers are cleared.
  - Reset mid-operation discards the operation; no done pulse is produced.
- FSM states:
  - IDLE: start=1 latches op, opa and opb, then goes to PREP. start while not IDLE is ignored.
  - PREP (1 cycle): convert signed operands to magnitudes and record the result signs. Load counter = WIDTH/STEPS_PER_CYCLE. Go to RUN.
  - RUN: each cycle retires STEPS_PER_CYCLE iterations.
    - Multiply: conditional add plus right shift of the {acc, multiplier} pair.
    - Divide: restoring subtract plus left shift of the {rem, quotient} pair.
    - The counter decrements each cycle; at 1, go to FIX.
  - FIX (1 cycle): apply sign correction and write HI/LO. Assert done in this cycle; the new HI/LO are visible the next cycle. Go to IDLE.
- Latency:
  - start sampled at edge t gives done high in cycle t + WIDTH/STEPS_PER_CYCLE + 1.
  - HI/LO are readable from cycle t + WIDTH/STEPS_PER_CYCLE + 2.
  - Default parameters: done at t+33, data at t+34.
- busy: high in PREP, RUN and FIX.
- stall rule: stall = (rd_req & busy) | (start & busy).
  - The pipeline holds a MFHI/MFLO, or a second mul/div, until the current operation completes.
- Simultaneous start and rd_req in IDLE: the read returns the old HI/LO with stall = 0, and the operation starts.
- Multiply results:
  - HI:LO is the full 2*WIDTH product.
  - MULT is signed; the product is negated in FIX if the operand signs differ.
  - MULTU is unsigned.
- Divide results:
  - LO = quotient, HI = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative / -1: LO = 0x80000000, HI = 0, no flag.
- Divide by zero (opb == 0):
  - Full latency is preserved.
  - LO = all ones, HI = opa (unsigned path; the signed path uses the same raw result).
  - div_zero is set at FIX and cleared at the next divide's FIX if that divisor is nonzero.
  - div_zero is not cleared by multiplies.

Optional Feature:
- Macro: MULDIV_MTHILO_EN.
- When defined, add three inputs:
  - wr_en, 1 bit.
  - wr_sel, 1 bit: 0 selects LO, 1 selects HI.
  - wr_data, WIDTH bits.
- Write semantics:
  - In IDLE, wr_en writes the selected register at the edge; rd_data reflects the new value the next cycle.
  - If wr_en and start occur in the same IDLE cycle, the write happens and the operation later overwrites HI/LO.
  - wr_en while busy raises stall (term added to the OR), and the write is deferred until the pipeline re-presents it.
- When undefined: the ports are absent, and HI/LO change only at FIX or reset.

Decomposition:
- Shared header, alongside the control.vh definitions:
  - Op encodings: MD_DIV, MD_DIVU, MD_MULT, MD_MULTU.
  - FSM state encodings: IDLE, PREP, RUN, FIX.
  - Default MD_WIDTH.
- One natural sub-module, muldiv_iter:
  - Holds the working registers and performs STEPS_PER_CYCLE shift-add/subtract steps per enable.
  - muldiv_sequencer keeps the FSM, the sign handling, HI/LO and the stall logic.

Test Plan:
- DIVU opa=100, opb=7, start at edge t: done at t+33; then HI=2, LO=14; busy low at t+34.
- DIV opa=0xFFFFFFF9 (-7), opb=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then opa=0x80000000, opb=0xFFFFFFFF: LO=0x80000000, HI=0.
- MULT 0xFFFFFFFF × 2: HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- DIVU opa=0x1234, opb=0: LO=0xFFFFFFFF, HI=0x1234, div_zero=1. A following DIVU 9/3 gives div_zero=0, LO=3, HI=0.
- MFLO (rd_req=1, rd_sel=0) held from t+1:
  - stall=1 through t+33, stall=0 at t+34 with rd_data = new LO.
  - A second start at t+5 is ignored and raises stall.
- Reset pulsed at t+10 of a MULT: all outputs 0 immediately (asynchronously); no done pulse; a fresh DIVU 100/7 then completes normally.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states, default width.
package muldiv_sequencer_pkg;
  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_DIV   = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MULT  = 2'b10,
    MD_MULTU = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  function automatic logic md_is_mul(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// Iterative magnitude datapath: shift-add multiply / restoring divide on a {hi, lo} pair,
// retiring STEPS_PER_CYCLE iterations per enabled cycle.
module muldiv_iter
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH           = MD_WIDTH,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             is_mul,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [WIDTH:0]   sum, shl;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    b_d  = b_q;
    sum  = '0;
    shl  = '0;
    diff = '0;
    ge   = 1'b0;
    if (load) begin
      hi_d = '0;
      lo_d = a_in;
      b_d  = b_in;
    end else if (en) begin
      for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
        if (is_mul) begin
          // lo holds the multiplier; its low bit gates the add, then {acc, lo} shifts right
          sum  = {1'b0, hi_d} + (lo_d[0] ? {1'b0, b_q} : '0);
          hi_d = sum[WIDTH:1];
          lo_d = {sum[0], lo_d[WIDTH-1:1]};
        end else begin
          // remainder stays below the divisor, so the low WIDTH bits of the difference suffice
          shl  = {hi_d, lo_d[WIDTH-1]};
          ge   = shl >= {1'b0, b_q};
          diff = shl[WIDTH-1:0] - b_q;
          hi_d = ge ? diff : shl[WIDTH-1:0];
          lo_d = {lo_d[WIDTH-2:0], ge};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller owning HI/LO, with MFHI/MFLO read and stall.
// Define MULDIV_MTHILO_EN to add the wr_en/wr_sel/wr_data HI/LO write port.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH           = MD_WIDTH,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             rd_req,
  input  logic             rd_sel,
`ifdef MULDIV_MTHILO_EN
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
`endif
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero
);
  localparam int NCYC = WIDTH / STEPS_PER_CYCLE;
  localparam int CW   = $clog2(NCYC + 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, it_hi, it_lo;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = md_is_signed(op_q) & opa_q[WIDTH-1];
  assign b_neg = md_is_signed(op_q) & opb_q[WIDTH-1];
  assign a_mag = a_neg ? -opa_q : opa_q;
  assign b_mag = b_neg ? -opb_q : opb_q;
  assign prod  = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};

  muldiv_iter #(.WIDTH(WIDTH), .STEPS_PER_CYCLE(STEPS_PER_CYCLE)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == PREP),
    .en     (state_q == RUN),
    .is_mul (md_is_mul(op_q)),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .hi     (it_hi),
    .lo     (it_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = FIX;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    done  = (state_q == FIX);
`ifdef MULDIV_MTHILO_EN
    stall = busy & (rd_req | start | wr_en);
`else
    stall = busy & (rd_req | start);
`endif
  end

  always_comb begin
    op_d   = op_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dz_d   = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = md_op_e'(op);
          opa_d = opa;
          opb_d = opb;
        end
`ifdef MULDIV_MTHILO_EN
        if (wr_en) begin
          if (wr_sel) hi_d = wr_data;
          else        lo_d = wr_data;
        end
`endif
      end
      PREP: begin
        cnt_d  = CW'(NCYC);
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
      end
      RUN: cnt_d = cnt_q - CW'(1);
      default: begin
        if (md_is_mul(op_q)) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (opb_q == '0) begin
          // divide by zero reports the raw dividend and an all-ones quotient, no sign fix
          hi_d = opa_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rneg_q ? -it_hi : it_hi;
          lo_d = neg_q ? -it_lo : it_lo;
          dz_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= MD_DIV;
      opa_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dz_q   <= dz_d;
    end
  end

  assign rd_data  = rd_sel ? hi_q : lo_q;
  assign div_zero = dz_q;
endmodule
